// File: rtl/serial_tx_arbiter.sv
// serial_tx_arbiter: round-robin arbiter that grants one of NUM_REQ
// requesters, captures its word and sends it on a shared serial line.
// Frame format: start bit (1), WORD_SIZE data bits MSB-first,
// optional even-parity bit, gap bit (0).
// Optional feature: define SERIAL_TX_PARITY_EN to add the parity bit.
module serial_tx_arbiter #(
  parameter int WORD_SIZE = 23,
  parameter int NUM_REQ   = 4,
  localparam int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*WORD_SIZE-1:0] req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         serial_out,
  output logic                         busy,
  output logic [ID_W-1:0]              grant_id
);

  localparam int CNT_W = (WORD_SIZE > 1) ? $clog2(WORD_SIZE) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    SHIFT,
`ifdef SERIAL_TX_PARITY_EN
    PARITY,
`endif
    GAP
  } state_t;

  state_t               state_q, state_d;
  logic [WORD_SIZE-1:0] shreg_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [ID_W-1:0]      rr_ptr_q;
  logic                 grant_found;
  logic [ID_W-1:0]      grant_idx;
  logic [WORD_SIZE-1:0] grant_word;
`ifdef SERIAL_TX_PARITY_EN
  logic                 parity_q;
`endif

  // Round-robin search: first valid requester at or above rr_ptr, wrapping.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path
    // leaves it unassigned and no latch is inferred.
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(idx);
      end
    end
    grant_word = req_data[int'(grant_idx)*WORD_SIZE +: WORD_SIZE];
  end

  // Next-state logic and the combinational grant pulse.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    unique case (state_q)
      IDLE: begin
        if (grant_found) begin
          state_d = START;
          // Gated by rst_n so no grant is offered while reset is held.
          if (rst_n) req_ready = NUM_REQ'(1) << grant_idx;
        end
      end
      START: state_d = SHIFT;
      SHIFT: begin
        if (cnt_q == '0) begin
`ifdef SERIAL_TX_PARITY_EN
          state_d = PARITY;
`else
          state_d = GAP;
`endif
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      PARITY: state_d = GAP;
`endif
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every register samples values
    // from before the edge, independent of statement order.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Datapath: capture on grant, shift out, and register the line value
  // for the state being entered so serial_out is glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q    <= '0;
      cnt_q      <= CNT_W'(WORD_SIZE - 1);
      rr_ptr_q   <= '0;
      grant_id   <= '0;
      serial_out <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      serial_out <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (grant_found) begin
            shreg_q    <= grant_word;
            grant_id   <= grant_idx;
            rr_ptr_q   <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + ID_W'(1);
            cnt_q      <= CNT_W'(WORD_SIZE - 1);
            serial_out <= 1'b1;
`ifdef SERIAL_TX_PARITY_EN
            parity_q   <= ^grant_word;
`endif
          end
        end
        START: begin
          serial_out <= shreg_q[WORD_SIZE-1];
          shreg_q    <= shreg_q << 1;
        end
        SHIFT: begin
          if (cnt_q != '0) begin
            serial_out <= shreg_q[WORD_SIZE-1];
            shreg_q    <= shreg_q << 1;
            cnt_q      <= cnt_q - CNT_W'(1);
          end else begin
            cnt_q <= CNT_W'(WORD_SIZE - 1);
`ifdef SERIAL_TX_PARITY_EN
            serial_out <= parity_q;
`endif
          end
        end
        default: serial_out <= 1'b0;
      endcase
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Testbench for serial_tx_arbiter: random and directed stimulus checked
// cycle by cycle against a frame-level model (a queue of line bits).
module tb_serial_tx_arbiter;

  localparam int W    = 23;
  localparam int N    = 4;
  localparam int ID_W = 2;
  localparam int EW   = 2 + ID_W + N;
`ifdef SERIAL_TX_PARITY_EN
  localparam int PERIOD = W + 4;
`else
  localparam int PERIOD = W + 3;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     req_valid = '0;
  logic [N*W-1:0]   req_data = '0;
  logic [N-1:0]     req_ready;
  logic             serial_out;
  logic             busy;
  logic [ID_W-1:0]  grant_id;

  serial_tx_arbiter #(.WORD_SIZE(W), .NUM_REQ(N)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .serial_out(serial_out), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model state: bits still to appear on the line, current line value.
  bit m_q[$];
  bit m_out, m_busy;
  int m_rr, m_gid;

  task automatic model_reset();
    m_q.delete();
    m_out = 0; m_busy = 0; m_rr = 0; m_gid = 0;
  endtask

  // Expected {serial_out, busy, grant_id, req_ready} for the current cycle,
  // then advance the model across the coming clock edge.
  task automatic model_cycle(output logic [EW-1:0] e);
    int pick = -1;
    logic [N-1:0] rdy = '0;
    logic [W-1:0] word;
    if (!m_busy)
      for (int k = 0; k < N; k++)
        if (pick < 0 && req_valid[(m_rr + k) % N]) pick = (m_rr + k) % N;
    if (pick >= 0) rdy[pick] = 1'b1;
    e = {m_out, m_busy, ID_W'(m_gid), rdy};
    if (pick >= 0) begin
      word = req_data[pick*W +: W];
      m_q.push_back(1'b1);
      for (int b = W - 1; b >= 0; b--) m_q.push_back(word[b]);
`ifdef SERIAL_TX_PARITY_EN
      m_q.push_back(^word);
`endif
      m_q.push_back(1'b0);
      m_gid = pick;
      m_rr  = (pick + 1) % N;
    end
    if (m_q.size() > 0) begin m_out = m_q.pop_front(); m_busy = 1; end
    else begin m_out = 0; m_busy = 0; end
  endtask

  function automatic logic [EW-1:0] observe();
    return {serial_out, busy, grant_id, req_ready};
  endfunction

  task automatic test_reset();
    logic [EW-1:0] o;
    rst_n = 1'b0;
    req_valid = '1;
    #1;
    o = observe();
    vectors++;
    if (o !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs got %h want %h", o, {EW{1'b0}});
    end
    repeat (2) @(posedge clk);
    #1;
    req_valid = '0;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_idle();
    logic [EW-1:0] e, o;
    req_valid = '0;
    for (int c = 0; c < 100; c++) begin
      req_data = {$urandom, $urandom, $urandom};
      @(negedge clk);
      model_cycle(e); o = observe(); vectors++;
      if (o !== e || o !== '0) begin
        miscompares++;
        $display("FAIL idle cyc %0d got %h want %h", c, o, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_single();
    logic [EW-1:0] e, o;
    logic [W-1:0] bits = '0;
    logic [W-1:0] word = 23'h5A5A5A;
    req_data[1*W +: W] = word;
    for (int c = 0; c < 28; c++) begin
      req_valid = (c == 0) ? 4'b0010 : 4'b0000;
      @(negedge clk);
      model_cycle(e); o = observe(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL single cyc %0d got %h want %h", c, o, e);
      end
      if (c == 0) begin
        vectors++;
        if (req_ready !== 4'b0010) begin
          miscompares++;
          $display("FAIL single_ready got %b want 0010", req_ready);
        end
      end
      if (c == 1) begin
        vectors++;
        if (serial_out !== 1'b1) begin
          miscompares++;
          $display("FAIL single_start got %b want 1", serial_out);
        end
      end
      if (c >= 2 && c <= W + 1) bits = {bits[W-2:0], serial_out};
      if (c == W + 2) begin
        vectors++;
`ifdef SERIAL_TX_PARITY_EN
        if (serial_out !== ^word) begin
`else
        if (serial_out !== 1'b0) begin
`endif
          miscompares++;
          $display("FAIL single_tail got %b", serial_out);
        end
      end
      @(posedge clk); #1;
    end
    vectors++;
    if (bits !== word) begin
      miscompares++;
      $display("FAIL single_bits got %h want %h", bits, word);
    end
  endtask

  task automatic test_round_robin();
    logic [EW-1:0] e, o;
    int order[$];
    int when[$];
    int exp_order[5] = '{0, 1, 2, 3, 0};
    for (int i = 0; i < N; i++) req_data[i*W +: W] = W'($urandom);
    req_valid = '1;
    for (int c = 0; c < 4 * PERIOD + 6; c++) begin
      @(negedge clk);
      model_cycle(e); o = observe(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL rr cyc %0d got %h want %h", c, o, e);
      end
      for (int i = 0; i < N; i++)
        if (req_ready[i]) begin order.push_back(i); when.push_back(c); end
      @(posedge clk); #1;
    end
    req_valid = '0;
    vectors++;
    if (order.size() < 5) begin
      miscompares++;
      $display("FAIL rr_count got %0d want 5", order.size());
    end else begin
      for (int g = 0; g < 5; g++) begin
        vectors++;
        if (order[g] !== exp_order[g]) begin
          miscompares++;
          $display("FAIL rr_order idx %0d got %0d want %0d", g, order[g], exp_order[g]);
        end
      end
      for (int g = 1; g < 5; g++) begin
        vectors++;
        if (when[g] - when[g-1] !== PERIOD) begin
          miscompares++;
          $display("FAIL rr_spacing idx %0d got %0d want %0d", g, when[g] - when[g-1], PERIOD);
        end
      end
    end
  endtask

  task automatic test_capture();
    logic [EW-1:0] e, o;
    logic [W-1:0] bits = '0;
    req_data[2*W +: W] = 23'h7FFFFF;
    req_valid = 4'b0100;
    for (int c = 0; c < PERIOD; c++) begin
      if (c == 5) req_data[2*W +: W] = '0;
      @(negedge clk);
      model_cycle(e); o = observe(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL capture cyc %0d got %h want %h", c, o, e);
      end
      if (c >= 2 && c <= W + 1) bits = {bits[W-2:0], serial_out};
      @(posedge clk); #1;
    end
    req_valid = '0;
    vectors++;
    if (bits !== 23'h7FFFFF) begin
      miscompares++;
      $display("FAIL capture_bits got %h want 7fffff", bits);
    end
  endtask

  task automatic test_random();
    logic [EW-1:0] e, o;
    for (int c = 0; c < 600; c++) begin
      req_valid = N'($urandom);
      for (int i = 0; i < N; i++) req_data[i*W +: W] = W'($urandom);
      @(negedge clk);
      model_cycle(e); o = observe(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL random cyc %0d got %h want %h", c, o, e);
      end
      @(posedge clk); #1;
    end
    req_valid = '0;
  endtask

  task automatic test_mid_reset();
    logic [EW-1:0] e, o;
    req_data[0*W +: W] = 23'h7FFFFF;
    for (int c = 0; c <= 10; c++) begin
      req_valid = (c == 0) ? 4'b0001 : 4'b0000;
      @(negedge clk);
      model_cycle(e); o = observe(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL midrst cyc %0d got %h want %h", c, o, e);
      end
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    req_valid = 4'b1000;
    #1;
    vectors++;
    if ({serial_out, busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL midrst_async got %b want 00", {serial_out, busy});
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      model_cycle(e); o = observe(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL postrst cyc %0d got %h want %h", c, o, e);
      end
      if (c == 0) begin
        vectors++;
        if (req_ready !== 4'b1000) begin
          miscompares++;
          $display("FAIL postrst_ready got %b want 1000", req_ready);
        end
      end
      if (c == 1) begin
        vectors++;
        if (grant_id !== 2'd3) begin
          miscompares++;
          $display("FAIL postrst_gid got %0d want 3", grant_id);
        end
      end
      @(posedge clk); #1;
    end
    req_valid = '0;
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_idle();
    test_single();
    test_reset();
    test_round_robin();
    test_reset();
    test_capture();
    test_reset();
    test_random();
    test_reset();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
